// File: rtl/ffsa.sv
// Sequential modular adder (A+B) mod P on 64-bit limbs, add and reduce pipelined.
// Optional busy output is enabled by defining FFSA_BUSY_EN.
module ffsa #(
   parameter logic [255:0] P = {64'h7fffffffffffffff, 64'hffffffffffffffff,
                                64'hffffffffffffffff, 64'hffffffffffffffed}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [254:0] a_i,
   input  logic [254:0] b_i,
   output logic [254:0] out,
   output logic         done
`ifdef FFSA_BUSY_EN
   ,
   output logic         busy
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      ADD0,
      ADD1,
      ADD2,
      ADD3,
      SUB3,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [255:0] a_r, b_r, s_r, d_r;
   logic         carry_r, borrow_r, borrow_f;

   logic         add_en, sub_en;
   logic [1:0]   add_k, sub_k;
   logic [63:0]  a_limb, b_limb, s_limb, p_limb;
   logic         carry_in, borrow_in;
   logic [64:0]  sum, diff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Limb k is added while limb k-1 of the sum is reduced against P.
   always_comb begin
      state_nx = state;
      add_en   = 1'b0;
      sub_en   = 1'b0;
      add_k    = 2'd0;
      sub_k    = 2'd0;
      unique case (state)
         IDLE: if (start) state_nx = ADD0;
         ADD0: begin
            add_en   = 1'b1;
            add_k    = 2'd0;
            state_nx = ADD1;
         end
         ADD1: begin
            add_en   = 1'b1;
            add_k    = 2'd1;
            sub_en   = 1'b1;
            sub_k    = 2'd0;
            state_nx = ADD2;
         end
         ADD2: begin
            add_en   = 1'b1;
            add_k    = 2'd2;
            sub_en   = 1'b1;
            sub_k    = 2'd1;
            state_nx = ADD3;
         end
         ADD3: begin
            add_en   = 1'b1;
            add_k    = 2'd3;
            sub_en   = 1'b1;
            sub_k    = 2'd2;
            state_nx = SUB3;
         end
         SUB3: begin
            sub_en   = 1'b1;
            sub_k    = 2'd3;
            state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      a_limb    = a_r[{add_k, 6'd0} +: 64];
      b_limb    = b_r[{add_k, 6'd0} +: 64];
      s_limb    = s_r[{sub_k, 6'd0} +: 64];
      p_limb    = P[{sub_k, 6'd0} +: 64];
      carry_in  = (add_k == 2'd0) ? 1'b0 : carry_r;
      borrow_in = (sub_k == 2'd0) ? 1'b0 : borrow_r;
      sum       = {1'b0, a_limb} + {1'b0, b_limb} + {64'd0, carry_in};
      diff      = {1'b0, s_limb} - {1'b0, p_limb} - {64'd0, borrow_in};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r      <= '0;
         b_r      <= '0;
         s_r      <= '0;
         d_r      <= '0;
         carry_r  <= 1'b0;
         borrow_r <= 1'b0;
         borrow_f <= 1'b0;
         out      <= '0;
         done     <= 1'b0;
      end else begin
         done <= (state == DONE);
         if (state == IDLE && start) begin
            a_r <= {1'b0, a_i};
            b_r <= {1'b0, b_i};
         end
         // Carry out of limb 3 is dropped: it is zero for inputs < 2^255.
         if (add_en) begin
            s_r[{add_k, 6'd0} +: 64] <= sum[63:0];
            carry_r                  <= sum[64];
         end
         if (sub_en) begin
            d_r[{sub_k, 6'd0} +: 64] <= diff[63:0];
            borrow_r                 <= diff[64];
            if (sub_k == 2'd3) borrow_f <= diff[64];
         end
         if (state == DONE)
            out <= borrow_f ? s_r[254:0] : d_r[254:0];
      end
   end

   logic unused_msb;
   assign unused_msb = d_r[255];

`ifdef FFSA_BUSY_EN
   assign busy = (state != IDLE);
`endif

endmodule

// File: tb/tb_ffsa.sv
// Directed self-checking bench for ffsa.
// Define FFSA_BUSY_EN for both files to also exercise busy.
module tb_ffsa;

   localparam logic [255:0] PF = {64'h7fffffffffffffff, 64'hffffffffffffffff,
                                  64'hffffffffffffffff, 64'hffffffffffffffed};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [254:0] a_i = '0;
   logic [254:0] b_i = '0;
   logic [254:0] out;
   logic         done;
`ifdef FFSA_BUSY_EN
   logic         busy;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ffsa dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a_i  (a_i),
      .b_i  (b_i),
      .out  (out),
      .done (done)
`ifdef FFSA_BUSY_EN
      ,
      .busy (busy)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start one op and expect done exactly 6 edges after capture.
   task automatic run_op(input string name, input logic [254:0] a,
                         input logic [254:0] b, input logic [254:0] exp);
      a_i   = a;
      b_i   = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i < 6 && done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s early_done cycle %0d got 1 want 0", name, i);
         end
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s done got %b want 1", name, done);
      end
      checks++;
      if (out !== exp) begin
         errors++;
         $display("FAIL %s out got %h want %h", name, out, exp);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done got %b want 0", done);
      end
      checks++;
      if (out !== '0) begin
         errors++;
         $display("FAIL reset_out got %h want 0", out);
      end
`ifdef FFSA_BUSY_EN
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
`endif
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      run_op("add_1_2", 255'd1, 255'd2, 255'd3);
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse_width got %b want 0", done);
      end
      checks++;
      if (out !== 255'd3) begin
         errors++;
         $display("FAIL out_hold got %h want 3", out);
      end
   endtask

   task automatic test_wrap();
      logic [255:0] pm1, pm2;
      pm1 = PF - 256'd1;
      pm2 = PF - 256'd2;
      run_op("pm1_plus_1", pm1[254:0], 255'd1, 255'd0);
      run_op("pm1_plus_pm1", pm1[254:0], pm1[254:0], pm2[254:0]);
   endtask

   task automatic test_carry();
      logic [254:0] one;
      one = 255'd1;
      run_op("carry_64", (one << 64) - one, one, one << 64);
      run_op("carry_192", (one << 192) - one, one, one << 192);
   endtask

   // start stays high; a_i glitches mid-op but is restored before recapture.
   task automatic test_back_to_back();
      int ndone;
      ndone = 0;
      a_i   = 255'd5;
      b_i   = 255'd7;
      start = 1'b1;
      for (int c = 0; c <= 20; c++) begin
         tick();
         if (c == 2) a_i = 255'd100;
         if (c == 4) a_i = 255'd5;
         if (c % 7 == 6) begin
            checks++;
            if (done !== 1'b1 || out !== 255'd12) begin
               errors++;
               $display("FAIL b2b_op cycle %0d done %b out %h want 1 / 12",
                        c, done, out);
            end
         end
         if (done === 1'b1) ndone++;
      end
      start = 1'b0;
      checks++;
      if (ndone != 3) begin
         errors++;
         $display("FAIL b2b_count got %0d want 3", ndone);
      end
      for (int c = 0; c < 7; c++) tick();
   endtask

   task automatic test_reset_abort();
      logic [255:0] a;
      int ndone;
      ndone = 0;
      a_i   = 255'd1;
      b_i   = 255'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (out !== '0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_async got out %h done %b want 0 / 0", out, done);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (done === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0 || out !== '0) begin
         errors++;
         $display("FAIL abort_nodone got %0d dones out %h want 0 / 0",
                  ndone, out);
      end
      a = PF - 256'd19;
      run_op("after_abort", a[254:0], 255'd40, 255'd21);
   endtask

`ifdef FFSA_BUSY_EN
   task automatic test_busy();
      int nbusy;
      nbusy = 0;
      a_i   = 255'd3;
      b_i   = 255'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (busy === 1'b1) nbusy++;
         tick();
      end
      checks++;
      if (nbusy != 6) begin
         errors++;
         $display("FAIL busy_cycles got %0d want 6", nbusy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_carry();
      test_back_to_back();
      test_reset_abort();
`ifdef FFSA_BUSY_EN
      test_busy();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ffsa.md
FFSA -- requirements
Module: ffsa

Interface
REQ-001 SHALL have parameter P, default 2^255-19 (256-bit), the field modulus.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port a_i  input  255  addend A, canonical (< P).
REQ-006 SHALL have port b_i  input  255  addend B, canonical (< P).
REQ-007 SHALL have port out  output  255  result (A+B) mod P.
REQ-008 SHALL have port done  output  1  one-cycle pulse; out valid.
REQ-009 SHALL have port busy  output  1  operation in progress (present only with FFSA_BUSY_EN).

Function
REQ-010 SHALL compute out = (a_i + b_i) mod P for canonical inputs; non-canonical inputs give unspecified out but the same timing.
REQ-011 SHALL use one 64-bit limb adder with carry chain and one 64-bit limb subtractor with borrow chain, operating on 256-bit zero-extended operands as four limbs, LS limb first.
REQ-012 SHALL have states IDLE, ADD0, ADD1, ADD2, ADD3, SUB3, DONE.
REQ-013 IDLE: start=1 SHALL capture a_i and b_i into internal 256-bit registers and go to ADD0; start=0 holds IDLE.
REQ-014 ADDk (k=0..3) SHALL store sum limb k (carry-in 0 for k=0, else the previous carry). In the same cycle, for k>=1, it SHALL subtract P limb k-1 from sum limb k-1 (borrow-in 0 for limb 0).
REQ-015 SHALL drop the carry out of sum limb 3; it is provably 0 for inputs < 2^255.
REQ-016 SUB3 SHALL subtract P limb 3 from sum limb 3, then go to DONE.
REQ-017 SHALL register the final borrow of D = S - P. out SHALL equal S[254:0] if that borrow is 1, else D[254:0].
REQ-018 DONE SHALL assert done for exactly one cycle, update out, and return to IDLE.
REQ-019 Latency: if start is sampled at edge 0, done SHALL be high after edge 6 and out valid in that same cycle.
REQ-020 Throughput: at most one operation per 7 cycles. start held high SHALL begin a new operation from every IDLE visit.
REQ-021 SHALL ignore start outside IDLE. a_i and b_i changes after capture SHALL not affect the result.
REQ-022 out SHALL hold its value from the done cycle until the next DONE.

Reset
REQ-023 rst SHALL force state IDLE, done=0, out=0, busy=0, and clear all limb, carry, borrow and operand registers, immediately and regardless of clk.
REQ-024 rst during an operation SHALL abort it with no done pulse. The next start after release SHALL complete normally.

Configuration
REQ-025 Macro FFSA_BUSY_EN defined: port busy SHALL exist. busy is high from the cycle after start is captured through the DONE cycle inclusive, and low in IDLE.
REQ-026 Macro FFSA_BUSY_EN undefined: port busy SHALL be absent. All other behaviour and timing SHALL be identical.

Verification
REQ-027 a=1, b=2, start pulse -> done 6 cycles later, out=3.
REQ-028 a=P-1, b=1 -> out=0. a=P-1, b=P-1 -> out=P-2.
REQ-029 a=2^64-1, b=1 -> out=2^64. a=2^192-1, b=1 -> out=2^192 (carry across limbs).
REQ-030 start high continuously with a=5, b=7 -> done every 7 cycles, out=12 each time. A mid-operation change of a_i does not alter out.
REQ-031 rst pulse 3 cycles after start -> no done, out=0. Then a=P-19, b=40 -> out=21.
REQ-032 With FFSA_BUSY_EN -> busy high for exactly 6 cycles per operation. Without it, build and run REQ-027..031 unchanged.
